// File: rtl/dlrm_pc_pkg.sv
// Shared definitions for the DLRM process-core front end: opcodes,
// instruction field layout and the issue sequencer state encoding.
package dlrm_pc_pkg;

   localparam int INSTR_W   = 64;
   localparam int OPCODE_W  = 4;
   localparam int OPCODE_LSB = 60;
   localparam int OPCODE_MSB = 63;
   localparam int ADDR_W    = 44;
   localparam int ADDR_LSB  = 16;
   localparam int ADDR_MSB  = 59;
   localparam int DATA_W    = 16;
   localparam int DATA_LSB  = 0;
   localparam int DATA_MSB  = 15;

   localparam logic [OPCODE_W-1:0] NOP          = 4'd0;
   localparam logic [OPCODE_W-1:0] READ_MEMORY  = 4'd1;
   localparam logic [OPCODE_W-1:0] WRITE_SWAP   = 4'd2;
   localparam logic [OPCODE_W-1:0] ACCUMULATE   = 4'd3;
   localparam logic [OPCODE_W-1:0] READ_BUFFER  = 4'd4;
   localparam logic [OPCODE_W-1:0] WRITE_BUFFER = 4'd5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      BUBBLE = 2'd2,
      STALL  = 2'd3
   } issue_state_e;

   function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INSTR_W-1:0] instr);
      return instr[OPCODE_MSB:OPCODE_LSB];
   endfunction

   function automatic logic is_legal_opcode(input logic [OPCODE_W-1:0] op);
      return (op >= READ_MEMORY) && (op <= WRITE_BUFFER);
   endfunction

endpackage

// File: rtl/pc_sync_fifo.sv
// Single-clock DEPTH x WIDTH queue with first-word fall-through read port,
// registered occupancy and a synchronous flush.
module pc_sync_fifo #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 64,
   localparam int CNT_W = $clog2(DEPTH) + 1,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_en;
   logic             pop_en;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign push_en  = push && !full && !flush;
   assign pop_en   = pop && !empty && !flush;
   assign pop_data = mem[rd_ptr];

   // NOTE: storage has no reset; contents are only read behind a valid count,
   // so resetting it would just add reset fan-out to every bit.
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_en, pop_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pc_instr_issuer.sv
// Instruction ingress queue and issue sequencer in front of the process core:
// filters illegal opcodes, issues one instruction then one NOP, honours backpressure.
module pc_instr_issuer
   import dlrm_pc_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               flush,
   output logic [INSTR_W-1:0] core_instr,
   input  logic               core_backpressure,
   output logic [CNT_W-1:0]   fifo_count,
   output logic [15:0]        illegal_count,
   output logic               idle
);

   issue_state_e       state;
   issue_state_e       state_nxt;
   logic               accept;
   logic               legal;
   logic               push;
   logic               drop;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [INSTR_W-1:0] head_instr;

   // full comes from the registered count, so a same-cycle pop cannot reopen in_ready
   assign in_ready = !fifo_full && !flush && reset_n;
   assign accept   = in_valid && in_ready;
   assign legal    = is_legal_opcode(get_opcode(in_instr));
   assign push     = accept && legal;
   assign drop     = accept && !legal;

   assign pop = !flush && !core_backpressure && !fifo_empty &&
                ((state == IDLE) || (state == BUBBLE));

   assign idle = fifo_empty && (state == IDLE);

   pc_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (INSTR_W)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .push      (push),
      .push_data (in_instr),
      .pop       (pop),
      .pop_data  (head_instr),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // NOTE: the default assignment at the top keeps this block latch-free
   // even if a branch below forgets to assign state_nxt.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!fifo_empty && !core_backpressure) state_nxt = ISSUE;
         end
         ISSUE: begin
            state_nxt = BUBBLE;
         end
         BUBBLE: begin
            if (core_backpressure)  state_nxt = STALL;
            else if (!fifo_empty)   state_nxt = ISSUE;
            else                    state_nxt = IDLE;
         end
         STALL: begin
            if (!core_backpressure) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // core_instr is nonzero only for the single cycle spent in ISSUE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         core_instr <= '0;
      end else if (flush) begin
         state      <= IDLE;
         core_instr <= '0;
      end else begin
         state      <= state_nxt;
         core_instr <= pop ? head_instr : '0;
      end
   end

   // flush deliberately leaves the drop statistics intact
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         illegal_count <= '0;
      end else if (drop && (illegal_count != 16'hFFFF)) begin
         illegal_count <= illegal_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_pc_instr_issuer.sv
// Directed self-checking bench for pc_instr_issuer: issue, back-to-back,
// illegal drop, backpressure stall, full queue, flush and reset.
module tb_pc_instr_issuer;

   logic        clk;
   logic        reset_n;
   logic [63:0] in_instr;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic [63:0] core_instr;
   logic        core_backpressure;
   logic [4:0]  fifo_count;
   logic [15:0] illegal_count;
   logic        idle;

   int checks   = 0;
   int failures = 0;

   pc_instr_issuer #(.DEPTH(16)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .in_instr          (in_instr),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .flush             (flush),
      .core_instr        (core_instr),
      .core_backpressure (core_backpressure),
      .fifo_count        (fifo_count),
      .illegal_count     (illegal_count),
      .idle              (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] full_vec(input int i);
      logic [3:0] op;
      op = 4'((i % 5) + 1);
      return {op, 44'(i + 100), 16'(i)};
   endfunction

   localparam logic [63:0] A  = 64'h1000_0000_ABCD_0001;
   localparam logic [63:0] B1 = 64'h1000_0000_0001_1111;
   localparam logic [63:0] B3 = 64'h3000_0000_0003_3333;
   localparam logic [63:0] B2 = 64'h2000_0000_0002_2222;
   localparam logic [63:0] L1 = 64'h4000_0000_0004_4444;
   localparam logic [63:0] I0 = 64'h0000_0000_0000_0BAD;
   localparam logic [63:0] I7 = 64'h7000_0000_0007_0BAD;
   localparam logic [63:0] L2 = 64'h5000_0000_0005_5555;
   localparam logic [63:0] P1 = 64'h1000_0000_0010_0001;
   localparam logic [63:0] P2 = 64'h2000_0000_0020_0002;
   localparam logic [63:0] P3 = 64'h3000_0000_0030_0003;
   localparam logic [63:0] P4 = 64'h4000_0000_0040_0004;
   localparam logic [63:0] X  = 64'h5000_0000_0050_000A;
   localparam logic [63:0] Y  = 64'h1000_0000_0050_000B;

   initial begin
      reset_n           = 1'b0;
      in_instr          = '0;
      in_valid          = 1'b0;
      flush             = 1'b0;
      core_backpressure = 1'b0;
      tick();
      check("rst_core",    core_instr, 64'd0);
      check("rst_count",   fifo_count, 64'd0);
      check("rst_illegal", illegal_count, 64'd0);
      check("rst_idle",    idle, 64'd1);
      check("rst_ready",   in_ready, 64'd0);
      reset_n = 1'b1;
      tick();
      check("post_rst_ready", in_ready, 64'd1);

      // basic issue
      in_valid = 1'b1; in_instr = A;
      tick();
      in_valid = 1'b0;
      check("basic_count1", fifo_count, 64'd1);
      check("basic_core0",  core_instr, 64'd0);
      tick();
      check("basic_issue",  core_instr, A);
      check("basic_count0", fifo_count, 64'd0);
      tick();
      check("basic_bubble", core_instr, 64'd0);
      check("basic_notidle", idle, 64'd0);
      tick();
      check("basic_idle",   idle, 64'd1);

      // back-to-back 1,3,2
      in_valid = 1'b1; in_instr = B1;
      tick();
      in_instr = B3;
      tick();
      check("b2b_i1",     core_instr, B1);
      check("b2b_cnt_e1", fifo_count, 64'd1);
      in_instr = B2;
      tick();
      in_valid = 1'b0;
      check("b2b_bub1",   core_instr, 64'd0);
      check("b2b_peak",   fifo_count, 64'd2);
      tick();
      check("b2b_i3",     core_instr, B3);
      check("b2b_cnt_e3", fifo_count, 64'd1);
      tick();
      check("b2b_bub2",   core_instr, 64'd0);
      tick();
      check("b2b_i2",     core_instr, B2);
      check("b2b_cnt_e5", fifo_count, 64'd0);
      tick();
      check("b2b_bub3",   core_instr, 64'd0);
      tick();
      check("b2b_idle",   idle, 64'd1);

      // illegal opcodes 0 and 7 between two legal instructions
      in_valid = 1'b1; in_instr = L1;
      tick();
      in_instr = I0;
      tick();
      check("ill_l1",      core_instr, L1);
      check("ill_cnt_a",   fifo_count, 64'd0);
      check("ill_drop1",   illegal_count, 64'd1);
      in_instr = I7;
      tick();
      check("ill_bub",     core_instr, 64'd0);
      check("ill_cnt_b",   fifo_count, 64'd0);
      in_instr = L2;
      tick();
      in_valid = 1'b0;
      check("ill_core_c",  core_instr, 64'd0);
      check("ill_cnt_c",   fifo_count, 64'd1);
      tick();
      check("ill_l2",      core_instr, L2);
      tick();
      check("ill_bub2",    core_instr, 64'd0);
      check("ill_total",   illegal_count, 64'd2);
      tick();
      check("ill_idle",    idle, 64'd1);

      // backpressure raised during a BUBBLE with 3 queued
      in_valid = 1'b1; in_instr = P1;
      tick();
      in_instr = P2;
      tick();
      check("bp_p1", core_instr, P1);
      in_instr = P3;
      tick();
      check("bp_bub", core_instr, 64'd0);
      core_backpressure = 1'b1;
      in_instr = P4;
      tick();
      in_valid = 1'b0;
      check("bp_stall_core", core_instr, 64'd0);
      check("bp_cnt3",       fifo_count, 64'd3);
      tick();
      tick();
      check("bp_stall_hold", core_instr, 64'd0);
      check("bp_cnt_hold",   fifo_count, 64'd3);
      core_backpressure = 1'b0;
      tick();
      check("bp_exit_idle",  core_instr, 64'd0);
      tick();
      check("bp_p2",         core_instr, P2);
      check("bp_cnt2",       fifo_count, 64'd2);
      tick();
      tick();
      check("bp_p3",         core_instr, P3);
      tick();
      tick();
      check("bp_p4",         core_instr, P4);
      tick();
      tick();
      check("bp_idle",       idle, 64'd1);

      // full queue with backpressure high
      core_backpressure = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_instr = full_vec(i);
         tick();
      end
      check("full_cnt16",   fifo_count, 64'd16);
      check("full_ready0",  in_ready, 64'd0);
      in_instr = full_vec(16);
      tick();
      tick();
      check("full_hold_cnt", fifo_count, 64'd16);
      check("full_hold_core", core_instr, 64'd0);
      core_backpressure = 1'b0;
      tick();
      check("full_f0",      core_instr, full_vec(0));
      check("full_cnt15",   fifo_count, 64'd15);
      check("full_ready1",  in_ready, 64'd1);
      tick();
      in_valid = 1'b0;
      check("full_cnt_back16", fifo_count, 64'd16);
      check("full_illegal",    illegal_count, 64'd2);
      for (int i = 1; i <= 16; i++) begin
         tick();
         check($sformatf("full_f%0d", i), core_instr, full_vec(i));
         tick();
         check($sformatf("full_bub%0d", i), core_instr, 64'd0);
      end
      tick();
      check("full_drained_idle", idle, 64'd1);

      // flush with 5 queued
      core_backpressure = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_instr = full_vec(i + 20);
         tick();
      end
      check("fl_cnt5", fifo_count, 64'd5);
      flush = 1'b1;
      in_instr = full_vec(30);
      #1;
      check("fl_ready0", in_ready, 64'd0);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      core_backpressure = 1'b0;
      check("fl_cnt0",    fifo_count, 64'd0);
      check("fl_core0",   core_instr, 64'd0);
      check("fl_idle",    idle, 64'd1);
      check("fl_illegal", illegal_count, 64'd2);
      tick();
      check("fl_no_issue", core_instr, 64'd0);

      // reset asserted mid-ISSUE
      in_valid = 1'b1; in_instr = X;
      tick();
      in_instr = Y;
      tick();
      in_valid = 1'b0;
      check("rs_issue_x", core_instr, X);
      check("rs_cnt1",    fifo_count, 64'd1);
      reset_n = 1'b0;
      #1;
      check("rs_core0",    core_instr, 64'd0);
      check("rs_cnt0",     fifo_count, 64'd0);
      check("rs_illegal0", illegal_count, 64'd0);
      check("rs_idle",     idle, 64'd1);
      check("rs_ready0",   in_ready, 64'd0);
      tick();
      reset_n = 1'b1;
      tick();
      tick();
      check("rs_after_core", core_instr, 64'd0);
      check("rs_after_idle", idle, 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_instr_issuer.md
# pc_instr_issuer

Instruction ingress queue and issue sequencer sitting directly upstream of the process core. It buffers 64-bit DLRM instructions from the host or scheduler, drops illegal opcodes, and drives the core's `instruction` input one instruction at a time. After every instruction it inserts one all-zero NOP cycle, so the core's default decode path clears its enables. It also stalls issue while the core raises `backpressure`.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `CNT_W`, `$clog2(DEPTH)+1`: occupancy width; derived, not overridden.

Ports:
- `clk` in 1: single clock; all logic is posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_instr` in 64: incoming instruction; opcode is `[63:60]`, address `[59:16]`, data `[15:0]`.
- `in_valid` in 1: `in_instr` is valid.
- `in_ready` out 1: queue can accept an instruction.
- `flush` in 1: synchronous queue clear.
- `core_instr` out 64: registered instruction to the core; 0 = NOP.
- `core_backpressure` in 1: the core's `backpressure` output.
- `fifo_count` out CNT_W: current occupancy.
- `illegal_count` out 16: saturating count of dropped instructions.
- `idle` out 1: FIFO empty and FSM in IDLE.

## Operation
- **Accept rule.** An instruction is accepted when `in_valid && in_ready`. `in_ready = !full && !flush && reset_n`.
- **Legal opcodes.** Legal opcodes are 1–5: READ_MEMORY, WRITE_SWAP, ACCUMULATE, READ_BUFFER, WRITE_BUFFER.
- **Illegal opcodes.** An accepted instruction with opcode 0 or 6–15 is consumed but not stored. `illegal_count` increments and saturates at 16'hFFFF.
- **Storage.** Legal instructions are written at `wr_ptr`. Pointers wrap modulo DEPTH.
- **Issue FSM states.**
  - IDLE: `core_instr`=0.
  - ISSUE: `core_instr`=head entry; the head is popped on entry.
  - BUBBLE: `core_instr`=0.
  - STALL: `core_instr`=0.
- **FSM transitions.**
  - IDLE→ISSUE when `fifo_count>0 && !core_backpressure`. Otherwise stay in IDLE.
  - ISSUE→BUBBLE unconditionally.
  - BUBBLE→STALL if `core_backpressure`; else →ISSUE if `fifo_count>0`; else →IDLE.
  - STALL→IDLE when `!core_backpressure`.
- **Occupancy.** On a simultaneous push (legal) and pop, `fifo_count` is unchanged. A dropped illegal instruction never changes the count.
- **Flush.**
  - Next edge: pointers, count and FSM go to 0/IDLE, and `core_instr`=0.
  - An instruction presented in the flush cycle is not accepted.
  - `illegal_count` is not cleared by flush.
- **Reset values (while `reset_n` is low).**
  - `core_instr`=0, `fifo_count`=0, `illegal_count`=0, `idle`=1, `in_ready`=0.
  - FSM=IDLE; pointers=0.
  - FIFO contents are don't-care.
- **Reset mid-operation.** Queued instructions are discarded. The core sees a NOP from the reset assertion onward.

## Timing
- **Latency.** An instruction accepted at edge N into an empty, idle queue with backpressure low appears on `core_instr` after edge N+1.
- **Throughput.** Maximum one instruction per 2 cycles, as ISSUE/BUBBLE alternate.
- **Backpressure sampling.** `core_backpressure` is sampled only in IDLE and BUBBLE. An instruction already in ISSUE is never retracted.
- **Stall exit.** Minimum STALL exit delay is IDLE then ISSUE, i.e. 2 cycles after backpressure drops.
- **Full queue.** `in_ready` drops in the same cycle `fifo_count`==DEPTH. A pop in that cycle does not raise `in_ready` until the next cycle, because `full` is taken from registered count.
- **Idle flag.** `idle` is combinational from registered state and count.

## Structure
- **Shared package `dlrm_pc_pkg`:**
  - opcode constants NOP=0, READ_MEMORY=1, WRITE_SWAP=2, ACCUMULATE=3, READ_BUFFER=4, WRITE_BUFFER=5;
  - instruction field positions/widths;
  - issue-state enum {IDLE, ISSUE, BUBBLE, STALL}.
- **Sub-module `pc_sync_fifo`:** parameterised DEPTH×64 storage with push/pop/count/full/empty. The issuer holds the opcode filter, FSM and counters.

## Test plan
- **Basic issue.** Push 64'h1000_0000_ABCD_0001 into an empty queue with backpressure 0 → `core_instr` equals it one cycle after acceptance, then 0 for one cycle, then `idle`=1.
- **Back-to-back.** Push opcodes 1,3,2 back-to-back → `core_instr` sequence instr1,0,instr3,0,instr2,0; `fifo_count` peaks at 2.
- **Illegal drop.** Push opcodes 0 and 7 between two legal instructions → the illegal ones never appear on `core_instr`; `illegal_count`=2; `fifo_count` is unaffected.
- **Backpressure.** Assert backpressure during a BUBBLE with 3 queued → STALL, `core_instr` held 0. Release → the next instruction issues exactly 2 cycles later, in order.
- **Full queue.** Fill DEPTH=16 entries with backpressure high → `in_ready`=0 at count 16; a 17th `in_valid` is held off with no loss.
- **Flush and reset.** Flush with 5 queued, then reset_n low mid-ISSUE → count 0, `core_instr`=0 immediately on reset assertion, `illegal_count` retained across flush but 0 after reset.
